led_pwm_controller: RTL and testbench

// - Per-LED brightness/pattern driver for board LEDs; generalises fixed LED count to num_leds channels.
// - Each channel has a mode (off/on/blink/breathe) and an 8-bit-default brightness, set via a valid/ready config port.
// - Drives board LED pins directly from the top level; one instance per board.

---
 rtl/led_pwm_pkg.sv | 27 ++
 rtl/led_pwm_channel.sv | 69 ++++++
 rtl/led_pwm_controller.sv | 139 +++++++++++++
 tb/tb_led_pwm_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared types for the LED PWM controller.
//   led_mode_t       : per-channel drive mode (off / on / blink / breathe)
//   led_brightness_t : widest brightness value a channel can hold
//   led_cfg_t        : one channel's configuration {mode, brightness}
// The brightness field is sized to the widest supported PWM resolution.
// Narrower instances zero-fill the upper bits.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        led_mode_off     = 2'd0,
        led_mode_on      = 2'd1,
        led_mode_blink   = 2'd2,
        led_mode_breathe = 2'd3
    } led_mode_t;

    localparam int led_max_brightness_width = 16;

    typedef logic [led_max_brightness_width-1:0] led_brightness_t;

    typedef struct packed {
        led_mode_t       mode;
        led_brightness_t brightness;
    } led_cfg_t;

    localparam led_cfg_t led_cfg_reset = '{mode: led_mode_off, brightness: '0};

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active configuration, duty selection and PWM compare.
//   clk, reset_n  : clock, synchronous active-low reset
//   wr_en, wr_cfg : configuration write into the shadow register
//   boundary      : last cycle of the PWM period; shadow is promoted to active
//   blink_phase   : shared blink phase (1 = lit half)
//   ramp          : shared breathe ramp level
//   pwm_cnt       : shared PWM counter
//   led           : registered LED drive, 1 = lit
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int brightness_width = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wr_en,
    input  led_cfg_t                    wr_cfg,
    input  logic                        boundary,
    input  logic                        blink_phase,
    input  logic [brightness_width-1:0] ramp,
    input  logic [brightness_width-1:0] pwm_cnt,
    output logic                        led
);

    localparam logic [brightness_width-1:0] duty_max = '1;
    localparam led_brightness_t chan_max =
        led_brightness_t'((64'd1 << brightness_width) - 64'd1);

    led_cfg_t                    shadow_cfg;
    led_cfg_t                    active_cfg;
    logic [brightness_width-1:0] brightness;
    logic [brightness_width-1:0] duty;

    // Active config only changes on the period boundary so a running PWM
    // period never sees a half-updated duty. A write landing on the
    // boundary cycle itself goes straight through to active.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_cfg <= led_cfg_reset;
            active_cfg <= led_cfg_reset;
            led        <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow_cfg <= wr_cfg;
            end
            if (boundary) begin
                active_cfg <= wr_en ? wr_cfg : shadow_cfg;
            end
            // Full-scale duty is held constantly lit instead of dipping
            // for the one count where pwm_cnt == max.
            led <= (pwm_cnt < duty) || (duty == duty_max);
        end
    end

    always_comb begin
        // A stored level beyond this channel's PWM range saturates to full-on.
        brightness = (active_cfg.brightness > chan_max) ? duty_max
                                                        : active_cfg.brightness[brightness_width-1:0];
        duty = '0;
        case (active_cfg.mode)
            led_mode_off:     duty = '0;
            led_mode_on:      duty = brightness;
            led_mode_blink:   duty = blink_phase ? brightness : '0;
            led_mode_breathe: duty = (ramp < brightness) ? ramp : brightness;
            default:          duty = '0;
        endcase
    end

endmodule

// File: rtl/led_pwm_controller.sv
// Multi-channel LED brightness / pattern driver.
//   clk, reset_n   : clock, synchronous active-low reset
//   cfg_valid      : configuration write request
//   cfg_ready      : configuration write accept (1 every cycle out of reset)
//   cfg_index      : target channel
//   cfg_mode       : channel mode
//   cfg_brightness : channel brightness level
//   cfg_error      : one-cycle pulse after an accepted write to a missing channel
//   period_strobe  : high in the last cycle of each PWM period
//   led            : LED drive, one bit per channel, 1 = lit
// Handshake: a write is taken on any rising edge where cfg_valid and
// cfg_ready are both 1; cfg_index/cfg_mode/cfg_brightness must be stable
// whenever cfg_valid is 1. The write goes to the channel's shadow register.
// Shadow registers are promoted to active on the next PWM period boundary.
module led_pwm_controller
    import led_pwm_pkg::*;
#(
    parameter int num_leds         = 4,
    parameter int brightness_width = 8,
    parameter int blink_periods    = 64,
    parameter int breathe_periods  = 2,
    localparam int index_width     = (num_leds > 1) ? $clog2(num_leds) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [index_width-1:0]      cfg_index,
    input  led_mode_t                   cfg_mode,
    input  logic [brightness_width-1:0] cfg_brightness,
    output logic                        cfg_error,
    output logic                        period_strobe,
    output logic [num_leds-1:0]         led
);

    localparam logic [brightness_width-1:0] pwm_max = '1;

    localparam int blink_cnt_width   = (blink_periods > 1) ? $clog2(blink_periods) : 1;
    localparam int breathe_cnt_width = (breathe_periods > 1) ? $clog2(breathe_periods) : 1;
    localparam logic [blink_cnt_width-1:0]   blink_last   = blink_cnt_width'(blink_periods - 1);
    localparam logic [breathe_cnt_width-1:0] breathe_last = breathe_cnt_width'(breathe_periods - 1);

    logic [brightness_width-1:0]  pwm_cnt;
    logic                         boundary;
    logic [blink_cnt_width-1:0]   blink_cnt;
    logic                         blink_phase;
    logic [breathe_cnt_width-1:0] breathe_cnt;
    logic [brightness_width-1:0]  ramp;
    logic                         ramp_falling;
    logic                         cfg_accept;
    logic                         index_valid;
    led_cfg_t                     wr_cfg;

    assign boundary      = (pwm_cnt == pwm_max);
    assign period_strobe = boundary;

    assign cfg_accept  = cfg_valid & cfg_ready;
    assign index_valid = (int'(cfg_index) < num_leds);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pwm_cnt   <= '0;
            cfg_ready <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + brightness_width'(1);
            cfg_ready <= 1'b1;
            cfg_error <= cfg_accept & ~index_valid;
        end
    end

    // Blink phase and breathe ramp advance only on period boundaries so
    // every channel switches pattern step at the same PWM edge.
    // The ramp is a triangle: it turns around on reaching max or 0, so
    // each end value is held for exactly one step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            breathe_cnt  <= '0;
            ramp         <= '0;
            ramp_falling <= 1'b0;
        end else if (boundary) begin
            if (blink_cnt == blink_last) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + blink_cnt_width'(1);
            end

            if (breathe_cnt == breathe_last) begin
                breathe_cnt <= '0;
                if (!ramp_falling) begin
                    if (ramp == pwm_max) begin
                        ramp         <= ramp - brightness_width'(1);
                        ramp_falling <= 1'b1;
                    end else begin
                        ramp <= ramp + brightness_width'(1);
                    end
                end else begin
                    if (ramp == '0) begin
                        ramp         <= ramp + brightness_width'(1);
                        ramp_falling <= 1'b0;
                    end else begin
                        ramp <= ramp - brightness_width'(1);
                    end
                end
            end else begin
                breathe_cnt <= breathe_cnt + breathe_cnt_width'(1);
            end
        end
    end

    always_comb begin
        wr_cfg      = led_cfg_reset;
        wr_cfg.mode = cfg_mode;
        wr_cfg.brightness[brightness_width-1:0] = cfg_brightness;
    end

    for (genvar i = 0; i < num_leds; i++) begin : g_chan
        logic wr_en;
        assign wr_en = cfg_accept & index_valid & (int'(cfg_index) == i);

        led_pwm_channel #(
            .brightness_width(brightness_width)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .wr_en       (wr_en),
            .wr_cfg      (wr_cfg),
            .boundary    (boundary),
            .blink_phase (blink_phase),
            .ramp        (ramp),
            .pwm_cnt     (pwm_cnt),
            .led         (led[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_controller.sv
// Bench for led_pwm_controller.
// A reference model runs on each rising edge. It works from the cycle count
// since reset and the number of period boundaries, and pushes the expected
// outputs for the following cycle into exp_q. A monitor on the falling edge
// pops each entry and compares it with the DUT outputs. Directed
// duty-count checks are added on top of the scoreboard.
module tb_led_pwm_controller;
    import led_pwm_pkg::*;

    localparam int NL = 5;
    localparam int BW = 5;
    localparam int BL = 2;
    localparam int BR = 2;
    localparam int IW = $clog2(NL);
    localparam int P  = 1 << BW;
    localparam int M  = P - 1;
    localparam int EW = NL + 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [IW-1:0] cfg_index = '0;
    led_mode_t     cfg_mode = led_mode_off;
    logic [BW-1:0] cfg_brightness = '0;
    logic          cfg_error;
    logic          period_strobe;
    logic [NL-1:0] led;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    logic [EW-1:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    led_pwm_controller #(
        .num_leds         (NL),
        .brightness_width (BW),
        .blink_periods    (BL),
        .breathe_periods  (BR)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_index      (cfg_index),
        .cfg_mode       (cfg_mode),
        .cfg_brightness (cfg_brightness),
        .cfg_error      (cfg_error),
        .period_strobe  (period_strobe),
        .led            (led)
    );

    // ---------------- reference model ----------------
    function automatic int ramp_at(input int b);
        int s;
        s = (b / BR) % (2 * M);
        return (s <= M) ? s : 2 * M - s;
    endfunction

    function automatic int duty_of(input led_mode_t md, input int br, input int b);
        int r;
        case (md)
            led_mode_on:      return br;
            led_mode_blink:   return (((b / BL) % 2) == 1) ? br : 0;
            led_mode_breathe: begin
                r = ramp_at(b);
                return (r < br) ? r : br;
            end
            default:          return 0;
        endcase
    endfunction

    bit        m_live = 0;
    bit        m_ready;
    int        m_t;
    int        m_b;
    led_mode_t sh_mode[NL];
    led_mode_t ac_mode[NL];
    int        sh_br[NL];
    int        ac_br[NL];

    initial begin
        forever begin
            logic [NL-1:0] e_led;
            logic          e_err;
            logic          e_strobe;
            bit            acc;
            int            pwm;
            int            d;
            int            idx;
            @(posedge clk);
            if (!reset_n) begin
                m_live  = 1;
                m_ready = 0;
                m_t     = 0;
                m_b     = 0;
                for (int i = 0; i < NL; i++) begin
                    sh_mode[i] = led_mode_off; ac_mode[i] = led_mode_off;
                    sh_br[i]   = 0;            ac_br[i]   = 0;
                end
                exp_q.push_back('0);
            end else if (m_live) begin
                pwm = m_t % P;
                for (int i = 0; i < NL; i++) begin
                    d = duty_of(ac_mode[i], ac_br[i], m_b);
                    e_led[i] = (pwm < d) || (d == M);
                end
                idx   = int'(cfg_index);
                acc   = cfg_valid && m_ready;
                e_err = acc && (idx >= NL);
                if (acc && idx < NL) begin
                    sh_mode[idx] = cfg_mode;
                    sh_br[idx]   = int'(cfg_brightness);
                end
                if (pwm == M) begin
                    for (int i = 0; i < NL; i++) begin
                        ac_mode[i] = sh_mode[i];
                        ac_br[i]   = sh_br[i];
                    end
                    m_b++;
                end
                m_t++;
                m_ready  = 1;
                e_strobe = ((m_t % P) == M);
                exp_q.push_back({e_led, 1'b1, e_err, e_strobe});
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            logic [EW-1:0] e;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pops++;
                n_tests++;
                if (led !== e[EW-1:3]) begin
                    n_fail++;
                    $display("FAIL led @%0t: got %b want %b", $time, led, e[EW-1:3]);
                end
                n_tests++;
                if ({cfg_ready, cfg_error, period_strobe} !== e[2:0]) begin
                    n_fail++;
                    $display("FAIL status(ready,err,strobe) @%0t: got %b want %b",
                             $time, {cfg_ready, cfg_error, period_strobe}, e[2:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; the write is sampled on the next rising edge.
    task automatic do_write(input int idx, input int mode, input int br);
        cfg_valid      = 1'b1;
        cfg_index      = IW'(idx);
        cfg_mode       = led_mode_t'(mode);
        cfg_brightness = BW'(br);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic count_led(input int ch, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (led[ch] === 1'b1) hi++;
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_boundary(output bit ok);
        ok = 0;
        for (int k = 0; k < 2 * P; k++) begin
            @(negedge clk);
            if (period_strobe === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hi;
        int want;
        bit ok;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("cfg_ready_in_reset", int'(cfg_ready), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("cfg_ready_after_reset", int'(cfg_ready), 1);

        // Idle: everything dark.
        hi = 0;
        repeat (1000) begin
            @(negedge clk);
            if (led !== '0) hi++;
        end
        check("idle_dark_cycles", hi, 0);

        // Channel 1 on at half scale.
        do_write(1, 1, P / 2);
        repeat (3 * P) @(negedge clk);
        count_led(1, P, hi);
        check("ch1_on_high_count", hi, P / 2);

        // Channel 0 full scale: constantly lit.
        do_write(0, 1, M);
        repeat (3 * P) @(negedge clk);
        count_led(0, 2 * P, hi);
        check("ch0_full_on", hi, 2 * P);

        // Channel 0 brightness 0: dark.
        do_write(0, 1, 0);
        repeat (3 * P) @(negedge clk);
        count_led(0, 2 * P, hi);
        check("ch0_zero_dark", hi, 0);

        // Channel 2 blink at 50%: one blink cycle = 2 lit periods + 2 dark.
        do_write(2, 2, P / 2);
        repeat (3 * P) @(negedge clk);
        count_led(2, 2 * BL * P, hi);
        check("ch2_blink_high_count", hi, BL * (P / 2));

        // Channel 3 breathe clamped below max, channel 4 breathe at max.
        do_write(3, 3, 25);
        do_write(4, 3, M);
        repeat (3 * P) @(negedge clk);
        want = 0;
        for (int s = 0; s < 2 * M; s++) begin
            int r;
            r = (s <= M) ? s : 2 * M - s;
            want += BR * ((r < 25) ? r : 25);
        end
        count_led(3, 2 * M * BR * P, hi);
        check("ch3_breathe_high_count", hi, want);

        // Back-to-back writes to channel 0: the last one wins.
        do_write(0, 1, 10);
        do_write(0, 1, 20);
        repeat (3 * P) @(negedge clk);
        count_led(0, P, hi);
        check("ch0_last_write_wins", hi, 20);

        // Write to a missing channel: one error pulse.
        do_write(7, 1, M);
        hi = int'(cfg_error === 1'b1);
        repeat (3) begin
            @(negedge clk);
            if (cfg_error === 1'b1) hi++;
        end
        check("bad_index_error_pulses", hi, 1);

        // Write landing on the boundary cycle itself.
        wait_boundary(ok);
        check("boundary_seen", int'(ok), 1);
        do_write(1, 1, 5);
        count_led(1, P, hi);
        check("boundary_write_through", hi, 5);

        // Randomized writes, all indices including missing ones.
        for (int k = 0; k < 250; k++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            do_write($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, M));
        end
        repeat (2 * P) @(negedge clk);

        // Reset mid-period: everything goes dark and back to off.
        repeat (P / 2 + 3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("led_after_mid_reset", int'(led), 0);
        reset_n = 1'b1;
        hi = 0;
        repeat (200) begin
            @(negedge clk);
            if (led !== '0) hi++;
        end
        check("dark_after_mid_reset", hi, 0);

        @(negedge clk);
        check("scoreboard_active", int'(n_pops > 10000), 1);
        check("scoreboard_drained", int'(exp_q.size() <= 1), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
